// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory requests for loads/stores, stalls on
// dm_ready, formats load data and registers the MEM/WB fields.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_lui_out,
  input  logic [31:0] ex_store_data,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        mem_stall,
  output logic [6:0]  MEM_WBk,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_lui_out,
  output logic [31:0] wb_DM_out,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write
);

  // state | meaning
  // IDLE  | no access outstanding; a memory op requests combinationally
  // WAIT  | access issued, holding request until dm_ready
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t      r_state, w_state_nxt;
  logic        w_is_load, w_is_store, w_mem_op;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  assign w_is_load  = ex_valid && (ex_opcode == OP_LOAD);
  assign w_is_store = ex_valid && (ex_opcode == OP_STORE);
  assign w_mem_op   = w_is_load | w_is_store;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    dm_req      = 1'b0;
    case (r_state)
      IDLE: begin
        dm_req = w_mem_op;
        if (w_mem_op && !dm_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        dm_req = 1'b1;
        if (dm_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mem_stall = dm_req & ~dm_ready;
  assign dm_addr   = dm_req ? {ex_alu_out[31:2], 2'b00} : 32'd0;

  // Sub-word stores place the data on every lane; the strobe picks the lane.
  always_comb begin
    dm_we    = 4'b0000;
    dm_wdata = 32'd0;
    if (dm_req && w_is_store) begin
      case (ex_funct3)
        3'b000: begin
          dm_we    = 4'b0001 << ex_alu_out[1:0];
          dm_wdata = {4{ex_store_data[7:0]}};
        end
        3'b001: begin
          dm_we    = 4'b0011 << {ex_alu_out[1], 1'b0};
          dm_wdata = {2{ex_store_data[15:0]}};
        end
        3'b010: begin
          dm_we    = 4'b1111;
          dm_wdata = ex_store_data;
        end
        default: begin
          dm_we    = 4'b0000;
          dm_wdata = 32'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = dm_rdata[7:0];
    case (ex_alu_out[1:0])
      2'b00: w_byte = dm_rdata[7:0];
      2'b01: w_byte = dm_rdata[15:8];
      2'b10: w_byte = dm_rdata[23:16];
      2'b11: w_byte = dm_rdata[31:24];
      default: w_byte = dm_rdata[7:0];
    endcase
    w_half = ex_alu_out[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ex_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_fmt = dm_rdata;
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = 32'd0;
    endcase
  end

  // A stall cycle inserts a bubble; data fields hold their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_WBk      <= 7'd0;
      wb_alu_out   <= 32'd0;
      wb_lui_out   <= 32'd0;
      wb_DM_out    <= 32'd0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
    end else if (mem_stall) begin
      MEM_WBk      <= 7'd0;
      wb_reg_write <= 1'b0;
    end else begin
      MEM_WBk      <= ex_valid ? ex_opcode : 7'd0;
      wb_alu_out   <= ex_alu_out;
      wb_lui_out   <= ex_lui_out;
      wb_DM_out    <= w_is_load ? w_load_fmt : 32'd0;
      wb_rd        <= ex_rd;
      wb_reg_write <= ex_valid & ex_reg_write;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus stall and
// reset-during-wait sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [31:0] ex_alu_out, ex_lui_out, ex_store_data;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ready;
  logic        mem_stall;
  logic [6:0]  MEM_WBk;
  logic [31:0] wb_alu_out, wb_lui_out, wb_DM_out;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_alu_out(ex_alu_out), .ex_lui_out(ex_lui_out), .ex_store_data(ex_store_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_stall(mem_stall),
    .MEM_WBk(MEM_WBk), .wb_alu_out(wb_alu_out), .wb_lui_out(wb_lui_out),
    .wb_DM_out(wb_DM_out), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu, lui, sdata, rdata;
    logic        ready;
    logic        e_req;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall;
    logic [6:0]  e_k;
    logic [31:0] e_dm;
    logic        e_rw;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                       input logic [31:0] lui, input logic [31:0] sd);
    ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_rd = rd; ex_reg_write = rw;
    ex_alu_out = alu; ex_lui_out = lui; ex_store_data = sd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                name       v  op     f3  rd rw alu           lui           sdata         rdata         rdy req we      addr          wdata        stl k      dm            rw
    vt[0]  = '{"lw",      1, 7'h03, 3'd0, 5'd3, 1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'hDEADBEEF, 1};
    vt[0].f3 = 3'd2;
    vt[1]  = '{"lhu",     1, 7'h03, 3'd5, 5'd4, 1, 32'h102, 32'h0, 32'h0, 32'h80011234, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'h00008001, 1};
    vt[2]  = '{"lh",      1, 7'h03, 3'd1, 5'd4, 1, 32'h102, 32'h0, 32'h0, 32'h80011234, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'hFFFF8001, 1};
    vt[3]  = '{"lb_pos",  1, 7'h03, 3'd0, 5'd6, 1, 32'h100, 32'h0, 32'h0, 32'h1234F07F, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'h0000007F, 1};
    vt[4]  = '{"lbu",     1, 7'h03, 3'd4, 5'd6, 1, 32'h101, 32'h0, 32'h0, 32'h1234F07F, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'h000000F0, 1};
    vt[5]  = '{"sb",      1, 7'h23, 3'd0, 5'd0, 0, 32'h201, 32'h0, 32'hAB, 32'h0, 1, 1, 4'b0010, 32'h200, 32'hABABABAB, 0, 7'h23, 32'h0, 0};
    vt[6]  = '{"sh",      1, 7'h23, 3'd1, 5'd0, 0, 32'h202, 32'h0, 32'h0000BEEF, 32'h0, 1, 1, 4'b1100, 32'h200, 32'hBEEFBEEF, 0, 7'h23, 32'h0, 0};
    vt[7]  = '{"sw_mis",  1, 7'h23, 3'd2, 5'd0, 0, 32'h303, 32'h0, 32'hCAFEF00D, 32'h0, 1, 1, 4'b1111, 32'h300, 32'hCAFEF00D, 0, 7'h23, 32'h0, 0};
    vt[8]  = '{"lui",     1, 7'h37, 3'd0, 5'd5, 1, 32'h0, 32'h12345000, 32'h0, 32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 7'h37, 32'h0, 1};
    vt[9]  = '{"inval",   0, 7'h03, 3'd2, 5'd7, 1, 32'h100, 32'h0, 32'h0, 32'h5555AAAA, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 7'h00, 32'h0, 0};
    vt[10] = '{"st_f3bad",1, 7'h23, 3'd3, 5'd0, 0, 32'h400, 32'h0, 32'h11223344, 32'h0, 1, 1, 4'b0000, 32'h400, 32'h0, 0, 7'h23, 32'h0, 0};
    vt[11] = '{"ld_f3bad",1, 7'h03, 3'd3, 5'd8, 1, 32'h100, 32'h0, 32'h0, 32'h12345678, 1, 1, 4'b0000, 32'h100, 32'h0, 0, 7'h03, 32'h0, 1};

    rst = 1'b0;
    drive(0, 7'h0, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    dm_rdata = 32'h0; dm_ready = 1'b0;
    #2;
    chk("rst_k", {25'd0, MEM_WBk}, 32'h0);
    chk("rst_dm", wb_DM_out, 32'h0);
    chk("rst_req", {31'd0, dm_req}, 32'h0);
    @(negedge clk); rst = 1'b1;
    tick();

    foreach (vt[i]) begin
      drive(vt[i].valid, vt[i].op, vt[i].f3, vt[i].rd, vt[i].rw, vt[i].alu, vt[i].lui, vt[i].sdata);
      dm_rdata = vt[i].rdata; dm_ready = vt[i].ready;
      @(negedge clk);
      chk({vt[i].name, "_req"},   {31'd0, dm_req}, {31'd0, vt[i].e_req});
      chk({vt[i].name, "_we"},    {28'd0, dm_we}, {28'd0, vt[i].e_we});
      chk({vt[i].name, "_addr"},  dm_addr, vt[i].e_addr);
      chk({vt[i].name, "_wdata"}, dm_wdata, vt[i].e_wdata);
      chk({vt[i].name, "_stall"}, {31'd0, mem_stall}, {31'd0, vt[i].e_stall});
      tick();
      chk({vt[i].name, "_k"},     {25'd0, MEM_WBk}, {25'd0, vt[i].e_k});
      chk({vt[i].name, "_dm"},    wb_DM_out, vt[i].e_dm);
      chk({vt[i].name, "_rw"},    {31'd0, wb_reg_write}, {31'd0, vt[i].e_rw});
      chk({vt[i].name, "_rd"},    {27'd0, wb_rd}, {27'd0, vt[i].rd});
      chk({vt[i].name, "_alu"},   wb_alu_out, vt[i].alu);
      chk({vt[i].name, "_lui"},   wb_lui_out, vt[i].lui);
    end

    // LB with two wait cycles: bubbles, held fields, then sign-extended byte 3
    drive(1, 7'h37, 3'd0, 5'd9, 1, 32'h0, 32'hABCDE000, 32'h0);
    dm_ready = 1'b1;
    tick();
    drive(1, 7'h03, 3'd0, 5'd7, 1, 32'h103, 32'h0, 32'h0);
    dm_ready = 1'b0; dm_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lbw_stall", {31'd0, mem_stall}, 32'h1);
      chk("lbw_req", {31'd0, dm_req}, 32'h1);
      chk("lbw_addr", dm_addr, 32'h100);
      tick();
      chk("lbw_bub_k", {25'd0, MEM_WBk}, 32'h0);
      chk("lbw_bub_rw", {31'd0, wb_reg_write}, 32'h0);
      chk("lbw_hold_rd", {27'd0, wb_rd}, 32'd9);
      chk("lbw_hold_lui", wb_lui_out, 32'hABCDE000);
    end
    dm_ready = 1'b1; dm_rdata = 32'h80FFFFFF;
    @(negedge clk);
    chk("lbw_stall_end", {31'd0, mem_stall}, 32'h0);
    chk("lbw_req_end", {31'd0, dm_req}, 32'h1);
    tick();
    chk("lbw_k", {25'd0, MEM_WBk}, 32'h03);
    chk("lbw_dm", wb_DM_out, 32'hFFFFFF80);
    chk("lbw_rd", {27'd0, wb_rd}, 32'd7);
    drive(0, 7'h0, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    dm_ready = 1'b0;
    @(negedge clk);
    chk("lbw_no_reissue", {31'd0, dm_req}, 32'h0);
    tick();

    // Reset while a load waits: abandon access, outputs clear at once
    drive(1, 7'h03, 3'd2, 5'd10, 1, 32'h500, 32'h0, 32'h0);
    dm_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rw_in_wait", {31'd0, mem_stall}, 32'h1);
    rst = 1'b0;
    drive(0, 7'h0, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rw_k", {25'd0, MEM_WBk}, 32'h0);
    chk("rw_alu", wb_alu_out, 32'h0);
    chk("rw_rd", {27'd0, wb_rd}, 32'h0);
    chk("rw_req", {31'd0, dm_req}, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rw_rel_req", {31'd0, dm_req}, 32'h0);
    chk("rw_rel_stall", {31'd0, mem_stall}, 32'h0);
    drive(1, 7'h03, 3'd2, 5'd11, 1, 32'h600, 32'h0, 32'h0);
    dm_ready = 1'b1; dm_rdata = 32'h0BADF00D;
    tick();
    chk("rw_resume_k", {25'd0, MEM_WBk}, 32'h03);
    chk("rw_resume_dm", wb_DM_out, 32'h0BADF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-low reset).
REQ-002 SHALL have ex_valid input 1 (EX/MEM slot holds a valid instruction); ex_opcode input 7; ex_funct3 input 3; ex_rd input 5; ex_reg_write input 1.
REQ-003 SHALL have ex_alu_out input 32 (ALU result; byte address for loads/stores); ex_lui_out input 32; ex_store_data input 32.
REQ-004 SHALL have dm_req output 1; dm_we output 4 (byte strobes, 0 = read); dm_addr output 32; dm_wdata output 32; dm_rdata input 32; dm_ready input 1.
REQ-005 SHALL have mem_stall output 1 (upstream must hold all ex_* stable while high).
REQ-006 SHALL have MEM/WB outputs: MEM_WBk output 7 (opcode); wb_alu_out output 32; wb_lui_out output 32; wb_DM_out output 32 (formatted load data); wb_rd output 5; wb_reg_write output 1.

Function
REQ-007 SHALL decode memory operations as load (opcode 0000011) and store (0100011) only when ex_valid=1.
REQ-008 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when a memory op is present and dm_ready=0; WAIT->IDLE on dm_ready=1; all other cases stay.
REQ-009 SHALL drive dm_req=1 combinationally in IDLE when a memory op is present, and throughout WAIT.
REQ-010 SHALL drive dm_addr={ex_alu_out[31:2],2'b00} whenever dm_req=1, else 0.
REQ-011 SHALL drive dm_we for stores as: SB (funct3 000) 4'b0001<<addr[1:0]; SH (001) 4'b0011<<{addr[1],1'b0}; SW (010) 4'b1111; loads and undefined funct3 4'b0000.
REQ-012 SHALL drive dm_wdata as the byte replicated 4x for SB, the halfword replicated 2x for SH, ex_store_data for SW, 0 otherwise.
REQ-013 SHALL treat address bits below natural alignment as ignored (no misalignment trap; halfword uses addr[1] only, word uses neither).
REQ-014 SHALL assert mem_stall = dm_req & ~dm_ready.
REQ-015 SHALL, on each rising edge with mem_stall=0, load MEM/WB registers from ex_* (MEM_WBk<=ex_valid?ex_opcode:0; wb_reg_write<=ex_valid&ex_reg_write).
REQ-016 SHALL, on each rising edge with mem_stall=1, load a bubble: MEM_WBk=0, wb_reg_write=0; other MEM/WB fields hold.
REQ-017 SHALL format load data from dm_rdata at completion: LB (000) sign-extended byte at addr[1:0]; LH (001) sign-extended half at addr[1]; LW (010) full word; LBU (100)/LHU (101) zero-extended; other funct3 -> 0.
REQ-018 SHALL register wb_DM_out only for completing loads; non-loads SHALL write 0 to wb_DM_out.
REQ-019 SHALL give 1-cycle latency ex->MEM/WB when dm_ready is high in the request cycle; N+1 cycles for N wait cycles.
REQ-020 SHALL ignore dm_ready and dm_rdata when dm_req=0.
REQ-021 SHALL not issue a second request for the same instruction after completion (completion edge consumes the ex_* slot).

Reset
REQ-022 SHALL, while rst=0, force FSM=IDLE and all MEM/WB outputs to 0 immediately (asynchronous).
REQ-023 SHALL, on reset asserted during WAIT, abandon the access; dm_req follows only combinational inputs after reset release with FSM in IDLE.
REQ-024 SHALL resume normal operation on the first rising edge after rst returns to 1.

Verification
REQ-025 LW, ex_alu_out=0x100, dm_ready=1, dm_rdata=0xDEADBEEF -> next edge MEM_WBk=0x03, wb_DM_out=0xDEADBEEF, mem_stall never 1.
REQ-026 LB addr=0x103, dm_rdata=0x80FFFFFF, dm_ready low 2 cycles -> mem_stall=1 for 2 cycles with bubbles (MEM_WBk=0); then wb_DM_out=0xFFFFFF80.
REQ-027 LHU addr=0x102, dm_rdata=0x8001_1234 -> wb_DM_out=0x00008001; LH same -> 0xFFFF8001.
REQ-028 SB addr=0x201, ex_store_data=0x000000AB -> dm_addr=0x200, dm_we=0010, dm_wdata=0xABABABAB, wb_reg_write=0.
REQ-029 LUI opcode 0110111, ex_lui_out=0x12345000, rd=5 -> dm_req=0, next edge MEM_WBk=0x37, wb_lui_out=0x12345000, wb_rd=5, wb_reg_write=1.
REQ-030 Load in WAIT, rst pulsed low -> all outputs 0 immediately, FSM IDLE; after release with ex_valid=0, dm_req=0.
